muldiv: RTL and testbench

- Parametrised, iterative multiply/divide unit for the MIPS-style core, sitting beside the combinational ALU in the execute stage.
- Provides MULT, MULTU, DIV, DIVU into internal HI/LO registers, plus single-cycle MTHI/MTLO writes.
- Uses a start/busy/done handshake, so the pipeline stalls on busy and reads hi/lo continuously.
- Generalises the ALU in width and adds multi-cycle, signed/unsigned modes it does not have.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_step.sv | 32 +++
 rtl/muldiv.sv | 147 ++++++++++++++
 tb/tb_muldiv.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// The ALU control decoder imports the same op constants.
package muldiv_pkg;

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  // op[1] selects divide and op[0] selects signed, for the iterative ops only
  function automatic logic op_is_iter(input logic [2:0] op);
    return op[2] == 1'b0;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract
// for divide. The accumulator holds {hi_part, lo_part}.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;
  logic           ge;

  always_comb begin
    // multiply: lo_part is the multiplier being consumed from the LSB
    sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    // divide: the shifted remainder needs one extra bit before the trial subtract
    rem_sh = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    ge     = rem_sh >= {1'b0, opnd_i};
    diff   = rem_sh - {1'b0, opnd_i};
    if (is_div_i) begin
      if (ge) acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      else    acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
    end else begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Operands are reduced to magnitudes up front; signs are restored in FIX.
module muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             divzero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 dz_q, dz_d;

  logic [2*WIDTH-1:0]   step_acc;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [2*WIDTH-1:0]   fix_prod;
  logic [WIDTH-1:0]     fix_quo, fix_rem;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (is_div_q),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dz_d      = dz_q;
    done_d    = 1'b0;

    // |INT_MIN| wraps to itself, which is the correct unsigned magnitude
    abs_a    = (op[0] && a[WIDTH-1]) ? -a : a;
    abs_b    = (op[0] && b[WIDTH-1]) ? -b : b;
    fix_prod = neg_q ? -acc_q : acc_q;
    fix_quo  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    fix_rem  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end else if (op_is_iter(op)) begin
            dz_d      = 1'b0;
            is_div_d  = op[1];
            cnt_d     = CNT_W'(WIDTH);
            neg_d     = op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_d = op[0] & op[1] & a[WIDTH-1];
            opnd_d    = op[1] ? abs_b : abs_a;
            acc_d     = {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
            state_d   = S_CALC;
            if (op[1] && (b == '0)) begin
              // preload the final result so FIX just copies it out unchanged
              dz_d      = 1'b1;
              acc_d     = {a, {WIDTH{1'b1}}};
              neg_d     = 1'b0;
              neg_rem_d = 1'b0;
              state_d   = S_FIX;
            end
          end
        end
      end
      S_CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          hi_d = fix_rem;
          lo_d = fix_quo;
        end else begin
          hi_d = fix_prod[2*WIDTH-1:WIDTH];
          lo_d = fix_prod[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign divzero = dz_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_muldiv.sv
// Directed bench for muldiv at WIDTH=32: products, quotients, divide by zero,
// busy/done timing, start-while-busy, MTHI/MTLO and mid-op reset.
module tb_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, divzero;
  logic [W-1:0] hi, lo;

  int tests = 0;
  int fails = 0;

  muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .divzero(divzero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Must be called at a negedge; returns at the negedge where done is seen.
  task automatic run_iter(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat, output int busy_cnt, output logic dz0);
    op = o; a = x; b = y; start = 1'b1;
    lat = -1; busy_cnt = 0; dz0 = 1'bx;
    @(posedge clk);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0;
        dz0 = divzero;
      end
      if (busy) busy_cnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({hi, lo, busy, done, divzero} !== {(2*W+3){1'b0}}) begin
      fails++; $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b dz=%b, expected all zero", hi, lo, busy, done, divzero);
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle: busy=%b expected 0", busy); end
  endtask

  task automatic test_multu();
    int lat, bc; logic dz0;
    run_iter(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, dz0);
    tests++;
    if (lat !== 33) begin fails++; $display("FAIL multu_latency: got %0d expected 33", lat); end
    tests++;
    if (bc !== 33) begin fails++; $display("FAIL multu_busy_cycles: got %0d expected 33", bc); end
    tests++;
    if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
      fails++; $display("FAIL multu_result: got %h_%h expected fffffffe_00000001", hi, lo);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL multu_done_pulse: done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_mult();
    int lat, bc; logic dz0;
    run_iter(3'b001, 32'hFFFF_FFFD, 32'd5, lat, bc, dz0);
    tests++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      fails++; $display("FAIL mult_neg: got %h_%h expected ffffffff_fffffff1", hi, lo);
    end
    @(negedge clk);
    run_iter(3'b001, 32'h8000_0000, 32'h8000_0000, lat, bc, dz0);
    tests++;
    if ({hi, lo} !== 64'h4000_0000_0000_0000) begin
      fails++; $display("FAIL mult_intmin_sq: got %h_%h expected 40000000_00000000", hi, lo);
    end
  endtask

  task automatic test_div();
    int lat, bc; logic dz0;
    @(negedge clk);
    run_iter(3'b011, 32'hFFFF_FFF9, 32'd2, lat, bc, dz0);
    tests++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      fails++; $display("FAIL div_neg_dividend: lo=%h hi=%h expected fffffffd ffffffff", lo, hi);
    end
    tests++;
    if (lat !== 33) begin fails++; $display("FAIL div_latency: got %0d expected 33", lat); end
    @(negedge clk);
    run_iter(3'b011, 32'd7, 32'hFFFF_FFFE, lat, bc, dz0);
    tests++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'd1) begin
      fails++; $display("FAIL div_neg_divisor: lo=%h hi=%h expected fffffffd 00000001", lo, hi);
    end
    @(negedge clk);
    run_iter(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, dz0);
    tests++;
    if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
      fails++; $display("FAIL div_intmin_m1: lo=%h hi=%h expected 80000000 00000000", lo, hi);
    end
    @(negedge clk);
    run_iter(3'b010, 32'hFFFF_FFF9, 32'd2, lat, bc, dz0);
    tests++;
    if (lo !== 32'h7FFF_FFFC || hi !== 32'd1) begin
      fails++; $display("FAIL divu_large: lo=%h hi=%h expected 7ffffffc 00000001", lo, hi);
    end
  endtask

  task automatic test_divzero();
    int lat, bc; logic dz0;
    @(negedge clk);
    run_iter(3'b011, 32'h8000_0000, 32'd0, lat, bc, dz0);
    tests++;
    if (lat !== 1) begin fails++; $display("FAIL divzero_latency: got %0d expected 1", lat); end
    tests++;
    if (divzero !== 1'b1 || hi !== 32'h8000_0000 || lo !== 32'hFFFF_FFFF) begin
      fails++; $display("FAIL divzero_result: dz=%b hi=%h lo=%h expected 1 80000000 ffffffff", divzero, hi, lo);
    end
    @(negedge clk);
    tests++;
    if (divzero !== 1'b1) begin fails++; $display("FAIL divzero_sticky: got %b expected 1", divzero); end
    run_iter(3'b010, 32'd7, 32'd2, lat, bc, dz0);
    tests++;
    if (dz0 !== 1'b0) begin fails++; $display("FAIL divzero_clear: got %b expected 0", dz0); end
    tests++;
    if (lo !== 32'd3 || hi !== 32'd1) begin
      fails++; $display("FAIL divu_7_2: lo=%h hi=%h expected 00000003 00000001", lo, hi);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc; logic dz0;
    @(negedge clk);
    run_iter(3'b010, 32'd100, 32'd7, lat, bc, dz0);
    tests++;
    if (lo !== 32'd14 || hi !== 32'd2) begin
      fails++; $display("FAIL b2b_first: lo=%h hi=%h expected 0000000e 00000002", lo, hi);
    end
    // start is raised in the same cycle done is high
    run_iter(3'b000, 32'd1000, 32'd1000, lat, bc, dz0);
    tests++;
    if (lat !== 33 || lo !== 32'd1000000 || hi !== 32'd0) begin
      fails++; $display("FAIL b2b_second: lat=%0d lo=%h hi=%h expected 33 000f4240 00000000", lat, lo, hi);
    end
  endtask

  task automatic test_busy_ignore();
    int done_cnt = 0;
    @(negedge clk);
    op = 3'b000; a = 32'd6; b = 32'd7; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 5) begin
        op = 3'b010; a = 32'd9; b = 32'd3; start = 1'b1;
      end
      if (done) done_cnt++;
    end
    start = 1'b0;
    tests++;
    if (hi !== 32'd0 || lo !== 32'd42) begin
      fails++; $display("FAIL busy_ignore_result: hi=%h lo=%h expected 00000000 0000002a", hi, lo);
    end
    tests++;
    if (done_cnt !== 1 || busy !== 1'b0) begin
      fails++; $display("FAIL busy_ignore_done: dones=%0d busy=%b expected 1 0", done_cnt, busy);
    end
  endtask

  task automatic test_mthi_reset();
    int done_cnt = 0;
    logic nonzero = 1'b0;
    @(negedge clk);
    op = 3'b100; a = 32'h1234_5678; b = 32'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (hi !== 32'h1234_5678 || busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL mthi: hi=%h busy=%b done=%b expected 12345678 0 0", hi, busy, done);
    end
    op = 3'b101; a = 32'hCAFE_F00D; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (lo !== 32'hCAFE_F00D || hi !== 32'h1234_5678 || busy !== 1'b0) begin
      fails++; $display("FAIL mtlo: lo=%h hi=%h busy=%b expected cafef00d 12345678 0", lo, hi, busy);
    end
    op = 3'b110; a = 32'hDEAD_BEEF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (lo !== 32'hCAFE_F00D || hi !== 32'h1234_5678 || busy !== 1'b0) begin
      fails++; $display("FAIL reserved_op: lo=%h hi=%h busy=%b expected cafef00d 12345678 0", lo, hi, busy);
    end
    op = 3'b001; a = 32'd11; b = 32'd13; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    tests++;
    if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_midop: hi=%h lo=%h busy=%b expected 0 0 0", hi, lo, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) nonzero = 1'b1;
    end
    tests++;
    if (done_cnt !== 0 || nonzero !== 1'b0) begin
      fails++; $display("FAIL reset_abort: dones=%0d changed=%b expected 0 0", done_cnt, nonzero);
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_divzero();
    test_back_to_back();
    test_busy_ignore();
    test_mthi_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
